// File: rtl/shift_add_mult_ctrl.sv
// Sequencing controller for an iterative unsigned shift-add multiplier.
// One iteration per clock through a shared external 2*WIDTH-bit combinational adder.
module shift_add_mult_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   add_a,
    output logic [2*WIDTH-1:0]   add_b,
    input  logic [2*WIDTH-1:0]   add_sum
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic [2*WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]     w_mplier_step;
    logic [CW-1:0]        w_count_step;
    logic                 w_last;

    assign w_acc_step    = r_mplier[0] ? add_sum : r_acc;
    assign w_mplier_step = r_mplier >> 1;
    assign w_count_step  = CW'(r_count + 1'b1);
    // Early exit fires once no multiplier bits remain to contribute to the sum
    assign w_last        = (w_count_step == CW'(WIDTH)) ||
                           (EARLY_EXIT && (w_mplier_step == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        add_a = '0;
        add_b = '0;
        if (r_state == S_RUN) begin
            add_a = r_acc;
            add_b = r_mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_step;
                    r_count  <= w_count_step;
                    if (w_last) r_product <= w_acc_step;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: one full-length and one early-exit instance,
// each with a behavioural adder; monitors pop expected products on every done pulse.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        busy0, done0, busy1, done1;
    logic [15:0] product0, add_a0, add_b0, sum0;
    logic [15:0] product1, add_a1, add_b1, sum1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    logic        prev0 = 1'b0, prev1 = 1'b0;
    logic [15:0] e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sum0 = add_a0 + add_b0;
    assign sum1 = add_a1 + add_b1;

    shift_add_mult_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .product(product0),
        .add_a(add_a0), .add_b(add_b0), .add_sum(sum0)
    );

    shift_add_mult_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .product(product1),
        .add_a(add_a1), .add_b(add_b1), .add_sum(sum1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done0) begin
            chk("d0_pulse_width", {31'd0, prev0}, 32'd0);
            chk("d0_busy_in_done", {31'd0, busy0}, 32'd1);
            chk("d0_adder_idle", {add_a0, add_b0}, 32'd0);
            if (exp0.size() == 0) begin
                total++; bad++;
                $display("FAIL d0_unexpected_done got=%0h expected=none", product0);
            end else begin
                e0 = exp0.pop_front();
                chk("d0_product", {16'd0, product0}, {16'd0, e0});
            end
        end
        prev0 <= done0;
    end

    always @(negedge clk) begin
        if (done1) begin
            chk("d1_pulse_width", {31'd0, prev1}, 32'd0);
            if (exp1.size() == 0) begin
                total++; bad++;
                $display("FAIL d1_unexpected_done got=%0h expected=none", product1);
            end else begin
                e1 = exp1.pop_front();
                chk("d1_product", {16'd0, product1}, {16'd0, e1});
            end
        end
        prev1 <= done1;
    end

    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] ev, input int exp_lat, input int glitch);
        int w;
        int lat;
        w = 0;
        while ((sel != 0 ? busy1 : busy0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (sel != 0) exp1.push_back(ev); else exp0.push_back(ev);
        @(negedge clk);
        if (sel != 0) begin a1 = av; b1 = bv; start1 = 1'b1; end
        else          begin a0 = av; b0 = bv; start0 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        lat = 1;
        while (!(sel != 0 ? done1 : done0) && lat < 30) begin
            if (lat == glitch) begin
                if (sel != 0) begin a1 = 8'd1; b1 = 8'd1; start1 = 1'b1; end
                else          begin a0 = 8'd1; b0 = 8'd1; start0 = 1'b1; end
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0; start1 = 1'b0;
        chk("latency", lat, exp_lat);
    endtask

    logic [7:0]  sa [5] = '{8'h03, 8'hA0, 8'hFF, 8'h80, 8'h00};
    logic [7:0]  sb [5] = '{8'h04, 8'h0F, 8'h01, 8'h80, 8'h55};
    logic [15:0] se [5] = '{16'h000C, 16'h0960, 16'h00FF, 16'h4000, 16'h0000};

    initial begin
        int w;
        int prev_cyc;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", {31'd0, busy0}, 0);
        chk("rst_done0", {31'd0, done0}, 0);
        chk("rst_product0", {16'd0, product0}, 0);
        chk("rst_add_a0", {16'd0, add_a0}, 0);
        chk("rst_add_b0", {16'd0, add_b0}, 0);
        chk("rst_busy1", {31'd0, busy1}, 0);
        chk("rst_product1", {16'd0, product1}, 0);
        chk("rst_add_ab1", {add_a1, add_b1}, 0);
        rst = 1'b0;

        // Basic product and latency
        run_op(0, 8'h12, 8'h34, 16'h03A8, 9, 0);
        // Max operands, with a mid-run start that must be ignored
        run_op(0, 8'hFF, 8'hFF, 16'hFE01, 9, 3);
        repeat (12) @(negedge clk);
        chk("ignored_start_busy", {31'd0, busy0}, 0);
        chk("ignored_start_product", {16'd0, product0}, 32'h0000FE01);

        // Early-exit instance
        run_op(1, 8'h05, 8'h03, 16'h000F, 3, 0);
        run_op(1, 8'h37, 8'h00, 16'h0000, 2, 0);
        run_op(1, 8'h10, 8'h80, 16'h0800, 9, 0);

        // Abort mid-run with reset
        @(negedge clk);
        a0 = 8'hAA; b0 = 8'h55; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy0}, 0);
        chk("abort_done", {31'd0, done0}, 0);
        chk("abort_product", {16'd0, product0}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(0, 8'h07, 8'h09, 16'h003F, 9, 0);

        // Back-to-back stream with start held high
        @(negedge clk);
        a0 = sa[0]; b0 = sb[0]; exp0.push_back(se[0]); start0 = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            @(negedge clk);
            while (!done0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!done0) begin
                total++; bad++;
                $display("FAIL stream_timeout got=no_done expected=done k=%0d", k);
            end
            if (k > 0) chk("stream_period", cyc - prev_cyc, 10);
            prev_cyc = cyc;
            if (k < 4) begin
                a0 = sa[k+1]; b0 = sb[k+1]; exp0.push_back(se[k+1]);
            end else begin
                start0 = 1'b0;
            end
        end

        repeat (15) @(negedge clk);
        chk("queue0_drained", exp0.size(), 0);
        chk("queue1_drained", exp1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
